// File: rtl/lsu_align_seq_if.sv
// ---------------------------------------------------------------------------
// lsu_align_seq_if
// Bundles the core request/response handshake and the data-memory bus seen by
// the load/store sequencer.
//   req_*     : core load/store request (valid, we, funct3, addr, wdata)
//   req_ready : sequencer idle and able to accept
//   busy      : core stall while a request is in flight
//   rsp_*     : one-cycle completion pulse with error flag and load data
//   mem_*     : MemRead/MemWrite/addr/data_in/funct3 to memory, data_out back
// Modports:
//   master : environment side (core drives req_*, memory drives mem_rdata)
//   slave  : sequencer side
// ---------------------------------------------------------------------------
interface lsu_align_seq_if #(
    parameter int ADDR_W = 6
);
    logic              req_valid;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              req_ready;
    logic              busy;
    logic              rsp_valid;
    logic              rsp_err;
    logic [31:0]       rsp_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [2:0]        mem_funct3;
    logic [31:0]       mem_rdata;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, busy, rsp_valid, rsp_err, rsp_rdata,
               mem_read, mem_write, mem_addr, mem_wdata, mem_funct3
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, busy, rsp_valid, rsp_err, rsp_rdata,
               mem_read, mem_write, mem_addr, mem_wdata, mem_funct3
    );
endinterface

// File: rtl/lsu_align_seq.sv
// ---------------------------------------------------------------------------
// lsu_align_seq
// Multi-cycle load/store sequencer between the core and a byte-addressable
// data memory. Aligned accesses take one memory beat; with LSU_MISALIGN_EN
// defined, misaligned halfword/word accesses are split into byte beats (lbu/sb)
// and loads are reassembled and extended. Without LSU_MISALIGN_EN, misaligned
// halfword/word requests complete immediately with rsp_err.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (aborts any request in flight)
//   bus   : lsu_align_seq_if.slave (request, response and memory signals)
// Parameter:
//   ADDR_W : byte-address width, matches the memory address port
// ---------------------------------------------------------------------------
module lsu_align_seq #(
    parameter int ADDR_W = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    lsu_align_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [31:0]       rsp_rdata_q;

    logic              req_legal;
    logic              req_misaligned;
    logic              req_err;
    logic              last_beat;
    logic [31:0]       load_value;

    // Legality depends on direction: unsigned loads have no store counterpart.
    always_comb begin
        case (bus.req_funct3)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = ~bus.req_we;
            default:                req_legal = 1'b0;
        endcase
    end

    // funct3[1:0] gives the access size; bytes can never be misaligned.
    assign req_misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                            ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));

`ifdef LSU_MISALIGN_EN
    logic        split_q;
    logic [1:0]  beat_q;
    logic [31:0] asm_q;
    logic [31:0] asm_next;

    assign req_err   = ~req_legal;
    assign last_beat = ~split_q || (beat_q == (funct3_q[1] ? 2'd3 : 2'd1));

    // The assembly value includes the byte arriving this cycle, so the final
    // beat can hand the complete result straight to rsp_rdata.
    always_comb begin
        asm_next = asm_q;
        asm_next[{beat_q, 3'b000} +: 8] = bus.mem_rdata[7:0];
        load_value = bus.mem_rdata;
        if (split_q) begin
            case (funct3_q)
                3'b001:  load_value = {{16{asm_next[15]}}, asm_next[15:0]};
                3'b101:  load_value = {16'b0, asm_next[15:0]};
                default: load_value = asm_next;
            endcase
        end
    end
`else
    assign req_err    = ~req_legal | req_misaligned;
    assign last_beat  = 1'b1;
    assign load_value = bus.mem_rdata;
`endif

    // Request latch and IDLE -> ACC -> DONE -> IDLE sequencing; response
    // outputs are registered on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= 32'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'b0;
`ifdef LSU_MISALIGN_EN
            split_q     <= 1'b0;
            beat_q      <= 2'd0;
            asm_q       <= 32'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q     <= bus.req_we;
                        funct3_q <= bus.req_funct3;
                        addr_q   <= bus.req_addr;
                        wdata_q  <= bus.req_wdata;
                        if (req_err) begin
                            state       <= DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'b0;
                        end else begin
                            state <= ACC;
`ifdef LSU_MISALIGN_EN
                            split_q <= req_misaligned;
                            beat_q  <= 2'd0;
                            asm_q   <= 32'b0;
`endif
                        end
                    end
                end
                ACC: begin
`ifdef LSU_MISALIGN_EN
                    asm_q  <= asm_next;
                    beat_q <= beat_q + 2'd1;
`endif
                    if (last_beat) begin
                        state       <= DONE;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= we_q ? 32'b0 : load_value;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    rsp_err_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory strobes decode the state register directly so an asynchronous
    // reset removes them immediately; everything is zero outside ACC.
    always_comb begin
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = 32'b0;
        bus.mem_funct3 = 3'b000;
        if (state == ACC) begin
            bus.mem_read   = ~we_q;
            bus.mem_write  = we_q;
            bus.mem_addr   = addr_q;
            bus.mem_wdata  = wdata_q;
            bus.mem_funct3 = funct3_q;
`ifdef LSU_MISALIGN_EN
            if (split_q) begin
                bus.mem_addr   = addr_q + ADDR_W'(beat_q);
                bus.mem_funct3 = we_q ? 3'b000 : 3'b100;
                bus.mem_wdata  = {24'b0, wdata_q[{beat_q, 3'b000} +: 8]};
            end
`endif
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule
